// File: rtl/disco_ctrl.sv
// disco_ctrl: sector-granular disk controller moving SECTOR_WORDS words between internal storage and main memory.
// A seek delay precedes each transfer; stores to the all-ones boot sector are rejected.
module disco_ctrl #(
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 15,
   parameter int SECTOR_BITS    = 3,
   parameter int SEEK_CYCLES    = 4,
   parameter int MEM_ADDR_WIDTH = 8
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic                              cmd_wr,
   input  logic [ADDR_WIDTH-SECTOR_BITS-1:0] sector,
   input  logic [MEM_ADDR_WIDTH-1:0]         mem_base,
   output logic [MEM_ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]             mem_wdata,
   output logic                              mem_we,
   input  logic [DATA_WIDTH-1:0]             mem_rdata,
   output logic                              busy,
   output logic                              done,
   output logic                              err,
   input  logic [ADDR_WIDTH-1:0]             dbg_addr,
   output logic [DATA_WIDTH-1:0]             dbg_q
);
   typedef enum logic [2:0] {IDLE, SEEK, XFER, DONE, ERR} state_t;
   state_t                              r_state, w_next;
   logic                                r_wr;
   logic [ADDR_WIDTH-SECTOR_BITS-1:0]   r_sec;
   logic [MEM_ADDR_WIDTH-1:0]           r_base;
   logic [7:0]                          r_cnt;
   logic [SECTOR_BITS-1:0]              r_idx;
   logic [DATA_WIDTH-1:0]               r_mem [2**ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0]               w_addr;
   logic                                w_xfer;
   assign w_addr = {r_sec, r_idx};
   assign w_xfer = r_state == XFER;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = (cmd_wr && &sector) ? ERR : SEEK;
         SEEK:    if (r_cnt == 8'd1) w_next = XFER;
         XFER:    if (&r_idx) w_next = DONE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_wr    <= 1'b0;
         r_sec   <= '0;
         r_base  <= '0;
         r_cnt   <= '0;
         r_idx   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && start) begin
            r_wr   <= cmd_wr;
            r_sec  <= sector;
            r_base <= mem_base;
            r_cnt  <= 8'(SEEK_CYCLES);
            r_idx  <= '0;
         end
         if (r_state == SEEK) r_cnt <= r_cnt - 8'd1;
         if (w_xfer) r_idx <= r_idx + 1'b1;
      end
   end
   // Storage has no reset so it can map onto RAM; reset leaves r_state in IDLE, which blocks writes.
   always_ff @(posedge clk)
      if (w_xfer && r_wr) r_mem[w_addr] <= mem_rdata;
   assign mem_addr  = w_xfer ? r_base + MEM_ADDR_WIDTH'(r_idx) : r_base;
   assign mem_we    = w_xfer && !r_wr;
   assign mem_wdata = mem_we ? r_mem[w_addr] : '0;
   assign busy      = r_state == SEEK || w_xfer;
   assign done      = r_state == DONE || r_state == ERR;
   assign err       = r_state == ERR;
   assign dbg_q     = r_mem[dbg_addr];
endmodule

// File: tb/tb_disco_ctrl.sv
// tb_disco_ctrl: directed bench for disco_ctrl with a reference storage model and per-cycle output checks.
module tb_disco_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, cmd_wr = 1'b0;
   logic [11:0] sector = '0;
   logic [7:0]  mem_base = '0;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata, mem_rdata;
   logic        mem_we, busy, done, err;
   logic [14:0] dbg_addr = '0;
   logic [15:0] dbg_q;
   logic [15:0] rd_off = '0;
   logic [15:0] mdl [32768];
   int          n_cmp = 0, n_bad = 0;
   always #5 clk = ~clk;
   assign mem_rdata = rd_off + 16'(mem_addr);
   disco_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .cmd_wr(cmd_wr), .sector(sector),
      .mem_base(mem_base), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
      .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err),
      .dbg_addr(dbg_addr), .dbg_q(dbg_q)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic chk_sector(input logic [11:0] sec);
      for (int i = 0; i < 8; i++) begin
         dbg_addr = {sec, 3'(i)};
         #1;
         chk($sformatf("mem_%0h", dbg_addr), dbg_q, mdl[dbg_addr]);
      end
   endtask
   // Cycle 0 is the cycle start is sampled in; cycle n is observed at the falling edge inside it.
   task automatic xfer(input logic wr, input logic [11:0] sec, input logic [7:0] base,
                       input int pulse_at, input int rst_at);
      logic        x;
      logic [7:0]  ea;
      logic [14:0] wa;
      bit          seen;
      @(negedge clk);
      cmd_wr = wr; sector = sec; mem_base = base; start = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         start = (n == pulse_at);
         if (n == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_we", mem_we, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wdata", mem_wdata, 0);
            break;
         end
         x  = n >= 5 && n <= 12;
         ea = x ? base + 8'(n - 5) : base;
         wa = {sec, 3'(n - 5)};
         chk($sformatf("c%0d_busy", n), busy, n <= 12);
         chk($sformatf("c%0d_done", n), done, n == 13);
         chk($sformatf("c%0d_err", n), err, 0);
         chk($sformatf("c%0d_we", n), mem_we, x && !wr);
         chk($sformatf("c%0d_addr", n), mem_addr, ea);
         chk($sformatf("c%0d_wdata", n), mem_wdata, (x && !wr) ? mdl[wa] : 16'h0);
         if (x && wr) mdl[wa] = rd_off + {8'h0, ea};
      end
      start = 1'b0;
      if (rst_at != 0) begin
         seen = 0;
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         repeat (14) begin
            @(negedge clk);
            if (done || busy) seen = 1;
         end
         chk("rst_no_done", seen, 0);
      end
   endtask
   initial begin
      for (int i = 0; i < 32768; i++) mdl[i] = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_err", err, 0);
      chk("reset_we", mem_we, 0);
      chk("reset_addr", mem_addr, 0);
      chk("reset_wdata", mem_wdata, 0);
      rst_n = 1'b1;
      rd_off = 16'h1000;
      xfer(1'b1, 12'd2, 8'h10, 0, 0);
      chk_sector(12'd2);
      dbg_addr = 15'd16;
      #1 chk("s2_first", dbg_q, 16'h1010);
      dbg_addr = 15'd23;
      #1 chk("s2_last", dbg_q, 16'h1017);
      xfer(1'b0, 12'd2, 8'h40, 0, 0);
      xfer(1'b0, 12'd2, 8'hFC, 0, 0);
      @(negedge clk);
      cmd_wr = 1'b1; sector = 12'hFFF; mem_base = 8'h00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("err_done", done, 1);
      chk("err_err", err, 1);
      chk("err_busy", busy, 0);
      @(negedge clk);
      chk("err_done_clr", done, 0);
      chk("err_err_clr", err, 0);
      chk("err_busy_after", busy, 0);
      chk_sector(12'hFFF);
      xfer(1'b0, 12'hFFF, 8'h20, 0, 0);
      rd_off = 16'h5000;
      xfer(1'b1, 12'd3, 8'h80, 3, 0);
      chk_sector(12'd3);
      rd_off = 16'h2000;
      xfer(1'b1, 12'd5, 8'h30, 0, 0);
      rd_off = 16'h3000;
      xfer(1'b1, 12'd5, 8'h30, 0, 8);
      chk_sector(12'd5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
